// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the pipeline boundary register: state encodings,
// the default stall-counter width and an occupancy decode helper.
package pipe_stage_reg_pkg;

    typedef enum logic [1:0] {
        STG_EMPTY     = 2'b00,
        STG_FULL      = 2'b01,
        STG_SKID_FULL = 2'b10
    } stg_state_e;

    localparam int STG_CNT_W = 16;

    function automatic logic [1:0] stg_occ(stg_state_e st);
        case (st)
            STG_FULL:      return 2'd1;
            STG_SKID_FULL: return 2'd2;
            default:       return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready/data handshake bundle for one side of a pipeline boundary.
// The producer uses the master modport, the consumer the slave modport.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 32
) ();

    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with synchronous clear; used for stall and
// per-stage performance counters.
module pipe_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_p1;

    function automatic logic [CNT_W-1:0] sat_inc(logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end
        return v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_p1 <= '0;
        end else if (inc) begin
            cnt_p1 <= sat_inc(cnt_p1);
        end
    end

    assign cnt_o = cnt_p1;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register with valid/ready handshake, flush and an optional
// 2-entry skid buffer that keeps up_ready free of any path from dn.ready.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SKID   = 1,
    parameter int CNT_W  = STG_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    pipe_stage_reg_if.slave      up,
    pipe_stage_reg_if.master     dn,
    output logic [1:0]           occ_o,
    output logic [CNT_W-1:0]     stall_cnt_o
);

    stg_state_e        state_p1, state_nx;
    logic [DATA_W-1:0] main_p1, main_nx;
    logic [1:0]        occ_p1;
    logic              vld_p1;
    logic              up_ready;
    logic              fire_in;
    logic              fire_out;

    assign vld_p1   = (state_p1 != STG_EMPTY);
    assign fire_in  = up.valid & up_ready;
    assign fire_out = vld_p1 & dn.ready;

    generate
        if (SKID != 0) begin : g_skid
            logic [DATA_W-1:0] skid_p1, skid_nx;
            logic              rdy_p1;

            always_comb begin
                state_nx = state_p1;
                main_nx  = main_p1;
                skid_nx  = skid_p1;
                if (flush_i) begin
                    state_nx = STG_EMPTY;
                end else begin
                    case (state_p1)
                        STG_EMPTY: begin
                            if (fire_in) begin
                                state_nx = STG_FULL;
                                main_nx  = up.data;
                            end
                        end
                        STG_FULL: begin
                            if (fire_in && fire_out) begin
                                main_nx = up.data;
                            end else if (fire_in) begin
                                state_nx = STG_SKID_FULL;
                                skid_nx  = up.data;
                            end else if (fire_out) begin
                                state_nx = STG_EMPTY;
                            end
                        end
                        STG_SKID_FULL: begin
                            if (fire_out) begin
                                state_nx = STG_FULL;
                                main_nx  = skid_p1;
                            end
                        end
                        default: state_nx = STG_EMPTY;
                    endcase
                end
            end

            // p0 -> p1: ready is registered from the next state, rst only gates it
            always_ff @(posedge clk) begin
                if (rst) begin
                    state_p1 <= STG_EMPTY;
                    main_p1  <= '0;
                    rdy_p1   <= 1'b1;
                end else begin
                    state_p1 <= state_nx;
                    main_p1  <= main_nx;
                    rdy_p1   <= (state_nx != STG_SKID_FULL);
                end
            end

            always_ff @(posedge clk) begin
                skid_p1 <= skid_nx;
            end

            assign up_ready = rdy_p1 & ~rst;
        end else begin : g_single
            always_comb begin
                state_nx = state_p1;
                main_nx  = main_p1;
                if (flush_i) begin
                    state_nx = STG_EMPTY;
                end else if (fire_in) begin
                    state_nx = STG_FULL;
                    main_nx  = up.data;
                end else if (fire_out) begin
                    state_nx = STG_EMPTY;
                end
            end

            // p0 -> p1: single entry, ready follows dn.ready combinationally
            always_ff @(posedge clk) begin
                if (rst) begin
                    state_p1 <= STG_EMPTY;
                    main_p1  <= '0;
                end else begin
                    state_p1 <= state_nx;
                    main_p1  <= main_nx;
                end
            end

            assign up_ready = ~rst & (~vld_p1 | dn.ready);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_p1 <= 2'd0;
        end else begin
            occ_p1 <= stg_occ(state_nx);
        end
    end

    pipe_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (vld_p1 & ~dn.ready & ~flush_i),
        .cnt_o (stall_cnt_o)
    );

    assign up.ready = up_ready;
    assign dn.valid = vld_p1;
    assign dn.data  = main_p1;
    assign occ_o    = occ_p1;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one SKID=1 (CNT_W=2) and one SKID=0 instance,
// directed vectors plus a random phase, checked by a queue scoreboard.
module tb_pipe_stage_reg;

    localparam int CLK_HALF = 5;

    logic clk = 1'b0;
    always #CLK_HALF clk = ~clk;

    logic        rst;
    logic        uv [2];
    logic [31:0] ud [2];
    logic        dr [2];
    logic        fl [2];
    logic [1:0]  occ0, occ1;
    logic [1:0]  stall0;
    logic [15:0] stall1;

    pipe_stage_reg_if #(.DATA_W(32)) up0 ();
    pipe_stage_reg_if #(.DATA_W(32)) dn0 ();
    pipe_stage_reg_if #(.DATA_W(32)) up1 ();
    pipe_stage_reg_if #(.DATA_W(32)) dn1 ();

    assign up0.valid = uv[0];
    assign up0.data  = ud[0];
    assign dn0.ready = dr[0];
    assign up1.valid = uv[1];
    assign up1.data  = ud[1];
    assign dn1.ready = dr[1];

    pipe_stage_reg #(.DATA_W(32), .SKID(1), .CNT_W(2)) u_skid (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (fl[0]),
        .up          (up0),
        .dn          (dn0),
        .occ_o       (occ0),
        .stall_cnt_o (stall0)
    );

    pipe_stage_reg #(.DATA_W(32), .SKID(0), .CNT_W(16)) u_single (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (fl[1]),
        .up          (up1),
        .dn          (dn1),
        .occ_o       (occ1),
        .stall_cnt_o (stall1)
    );

    int          n_chk  = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    int unsigned mstall [2];
    bit          dz [2];

    task automatic chk(string nm, int s, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, s, act, exp, $time);
        end
    endtask

    function automatic int qsz(int s);
        return (s == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [31:0] qfront(int s);
        return (s == 0) ? q0[0] : q1[0];
    endfunction

    task automatic qpop(int s);
        if (s == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endtask

    task automatic qpush(int s, logic [31:0] d);
        if (s == 0) q0.push_back(d);
        else        q1.push_back(d);
    endtask

    task automatic qclr(int s);
        if (s == 0) q0.delete();
        else        q1.delete();
    endtask

    function automatic int unsigned smax(int s);
        return (s == 0) ? 32'd3 : 32'd65535;
    endfunction

    function automatic logic rdy_of(int s);
        return (s == 0) ? up0.ready : up1.ready;
    endfunction

    function automatic logic vld_of(int s);
        return (s == 0) ? dn0.valid : dn1.valid;
    endfunction

    function automatic logic [31:0] data_of(int s);
        return (s == 0) ? dn0.data : dn1.data;
    endfunction

    function automatic logic [31:0] occ_of(int s);
        return (s == 0) ? 32'(occ0) : 32'(occ1);
    endfunction

    function automatic logic [31:0] stall_of(int s);
        return (s == 0) ? 32'(stall0) : 32'(stall1);
    endfunction

    // Compare outputs to the model, then advance the model to the next edge.
    task automatic mon_step(int s, logic rdy, logic vld, logic [31:0] dat,
                            logic [31:0] occ, logic [31:0] stall);
        int   sz;
        logic exp_rdy;
        sz = qsz(s);
        if (s == 0) exp_rdy = !rst && (sz < 2);
        else        exp_rdy = !rst && (sz == 0 || dr[s]);
        chk("dn_valid", s, 32'(vld), 32'(sz > 0));
        chk("occ", s, occ, 32'(sz));
        chk("up_ready", s, 32'(rdy), 32'(exp_rdy));
        chk("stall_cnt", s, stall, mstall[s]);
        if (sz > 0)     chk("dn_data", s, dat, qfront(s));
        else if (dz[s]) chk("dn_data_rst", s, dat, 32'h0);
        if (rst) begin
            qclr(s);
            mstall[s] = 0;
            dz[s] = 1'b1;
        end else begin
            dz[s] = 1'b0;
            if (sz > 0 && !dr[s] && !fl[s] && mstall[s] < smax(s)) mstall[s]++;
            if (sz > 0 && dr[s]) qpop(s);
            if (fl[s])                   qclr(s);
            else if (uv[s] && exp_rdy)   qpush(s, ud[s]);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_step(0, up0.ready, dn0.valid, dn0.data, 32'(occ0), 32'(stall0));
            mon_step(1, up1.ready, dn1.valid, dn1.data, 32'(occ1), 32'(stall1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(int s, logic [31:0] d);
        int k;
        k = 0;
        uv[s] = 1'b1;
        ud[s] = d;
        @(negedge clk);
        while (!rdy_of(s) && k < 64) begin
            @(negedge clk);
            k++;
        end
        chk("send_accept", s, 32'(rdy_of(s)), 32'd1);
        @(posedge clk);
        #1;
        uv[s] = 1'b0;
    endtask

    initial begin
        #(2 * CLK_HALF * 60000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            uv[s] = 1'b1;
            ud[s] = 32'hDEAD0001;
            dr[s] = 1'b1;
            fl[s] = 1'b0;
            mstall[s] = 0;
            dz[s] = 1'b1;
        end

        // reset held 3 cycles with a payload offered
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        tick();
        tick();
        for (int s = 0; s < 2; s++) begin
            chk("rst_ready", s, 32'(rdy_of(s)), 32'd0);
            chk("rst_valid", s, 32'(vld_of(s)), 32'd0);
            chk("rst_occ", s, occ_of(s), 32'd0);
        end
        rst = 1'b0;
        uv[0] = 1'b0;
        uv[1] = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            chk("ready_after_rst", s, 32'(rdy_of(s)), 32'd1);
        end

        // streaming 0x10..0x17 through each instance
        for (int s = 0; s < 2; s++) begin
            dr[s] = 1'b1;
            for (int i = 0; i < 8; i++) begin
                send(s, 32'h10 + 32'(i));
                chk("stream_data", s, data_of(s), 32'h10 + 32'(i));
                chk("stream_occ", s, occ_of(s), 32'd1);
            end
            tick();
            tick();
            chk("stream_drain_occ", s, occ_of(s), 32'd0);
        end

        // flush with two entries held (SKID=1)
        dr[0] = 1'b0;
        send(0, 32'hB0);
        send(0, 32'hB1);
        chk("flush_pre_occ", 0, occ_of(0), 32'd2);
        uv[0] = 1'b1;
        ud[0] = 32'hBB;
        fl[0] = 1'b1;
        tick();
        fl[0] = 1'b0;
        uv[0] = 1'b0;
        chk("flush_occ", 0, occ_of(0), 32'd0);
        chk("flush_valid", 0, 32'(vld_of(0)), 32'd0);
        chk("flush_stall", 0, stall_of(0), 32'd1);
        dr[0] = 1'b1;
        tick();
        tick();

        // flush with one entry held (SKID=0)
        dr[1] = 1'b0;
        send(1, 32'hC0);
        chk("flush1_pre_occ", 1, occ_of(1), 32'd1);
        uv[1] = 1'b1;
        ud[1] = 32'hBB;
        fl[1] = 1'b1;
        tick();
        fl[1] = 1'b0;
        uv[1] = 1'b0;
        chk("flush1_occ", 1, occ_of(1), 32'd0);
        chk("flush1_stall", 1, stall_of(1), 32'd0);
        dr[1] = 1'b1;
        tick();
        tick();

        // back-pressure into the skid entry
        dr[0] = 1'b0;
        send(0, 32'hA0);
        send(0, 32'hA1);
        uv[0] = 1'b1;
        ud[0] = 32'hA2;
        tick();
        tick();
        chk("bp_occ", 0, occ_of(0), 32'd2);
        chk("bp_ready", 0, 32'(rdy_of(0)), 32'd0);
        chk("bp_head", 0, data_of(0), 32'hA0);
        dr[0] = 1'b1;
        send(0, 32'hA2);
        chk("bp_last", 0, data_of(0), 32'hA2);
        chk("bp_last_occ", 0, occ_of(0), 32'd1);
        tick();
        chk("bp_drain_occ", 0, occ_of(0), 32'd0);

        // stall counter saturation at CNT_W=2
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("sat_rst0", 0, stall_of(0), 32'd0);
        dr[0] = 1'b0;
        send(0, 32'hE0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("sat_stall", 0, stall_of(0), (k < 3) ? 32'(k) : 32'd3);
        end
        rst = 1'b1;
        tick();
        chk("sat_rst", 0, stall_of(0), 32'd0);
        rst = 1'b0;
        dr[0] = 1'b1;
        tick();

        // random traffic on both instances, ~5% flush
        for (int c = 0; c < 10000; c++) begin
            for (int s = 0; s < 2; s++) begin
                uv[s] = 1'($urandom_range(0, 1));
                ud[s] = $urandom;
                dr[s] = 1'($urandom_range(0, 1));
                fl[s] = 1'($urandom_range(0, 99) < 5);
            end
            tick();
        end
        for (int s = 0; s < 2; s++) begin
            uv[s] = 1'b0;
            dr[s] = 1'b1;
            fl[s] = 1'b0;
        end
        for (int k = 0; k < 4; k++) tick();
        for (int s = 0; s < 2; s++) begin
            chk("final_occ", s, occ_of(s), 32'd0);
        end

        @(negedge clk);
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
